// File: rtl/bin_to_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t   : FSM state encoding (2-bit), also exported on the debug port
//   BCD_NINE  : digit value used when the result saturates
//   cnt_width : width of an iteration counter able to hold 0..bin_width
package bin_to_bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   localparam logic [3:0] BCD_NINE = 4'h9;

   function automatic int cnt_width(input int bin_width);
      return $clog2(bin_width + 1);
   endfunction

endpackage

// File: rtl/bin_to_bcd_sequential_if.sv
// Request/result bundle of the binary-to-BCD converter.
//   start    : conversion request, accepted on a rising edge while busy=0
//   binary   : unsigned value, captured on the accepting edge only
//   busy     : from the cycle after acceptance through the done cycle
//   done     : one-cycle pulse, bcd/overflow carry a new result
//   overflow : the converted value did not fit in DIGITS decimal digits
//   bcd      : packed BCD result, digit 0 in bits [3:0]
//   state    : FSM state, debug observation only
// Handshake: start is a request sampled on every rising edge while busy=0;
// it is dropped (never queued) while busy=1. Completion is signalled by the
// done pulse and bcd/overflow then hold until the next commit or reset.
interface bin_to_bcd_sequential_if #(
   parameter int BIN_WIDTH = 20,
   parameter int DIGITS    = 6
);
   import bin_to_bcd_pkg::*;

   logic                  start;
   logic [BIN_WIDTH-1:0]  binary;
   logic                  busy;
   logic                  done;
   logic                  overflow;
   logic [4*DIGITS-1:0]   bcd;
   state_t                state;

   modport master (
      output start, binary,
      input  busy, done, overflow, bcd, state
   );

   modport slave (
      input  start, binary,
      output busy, done, overflow, bcd, state
   );

endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or
// more, so that the following left shift carries into the next digit.
//   digit_in  : scratch digit before the shift
//   digit_out : corrected digit
module bcd_digit_adjust (
   input  logic [3:0] digit_in,
   output logic [3:0] digit_out
);

   assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin_to_bcd_sequential.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock. Feeds the hex-to-seven-segment encoder; the result registers only
// change at commit so the display never shows intermediate values.
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : start/binary in, busy/done/overflow/bcd/state out
module bin_to_bcd_sequential
   import bin_to_bcd_pkg::*;
#(
   parameter int BIN_WIDTH = 20,
   parameter int DIGITS    = 6
) (
   input  logic                    clock,
   input  logic                    reset,
   bin_to_bcd_sequential_if.slave  bus
);

   localparam int BCD_MSB   = (4 * DIGITS) - 1;
   localparam int CNT_WIDTH = cnt_width(BIN_WIDTH);
   localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(BIN_WIDTH - 1);

   state_t                state;
   logic [BIN_WIDTH-1:0]  shift_bin;
   logic [BCD_MSB:0]      scratch;
   logic [BCD_MSB:0]      adjusted;
   logic [BCD_MSB:0]      next_scratch;
   logic [BCD_MSB:0]      bcd_q;
   logic [CNT_WIDTH-1:0]  count;
   logic                  ovf_latch;
   logic                  carry;
   logic                  busy_q;
   logic                  done_q;
   logic                  ovf_q;

   // All digits are corrected in parallel before the shift.
   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_adjust u_adjust (
         .digit_in  (scratch[4*g +: 4]),
         .digit_out (adjusted[4*g +: 4])
      );
   end

   assign next_scratch = {adjusted[BCD_MSB-1:0], shift_bin[BIN_WIDTH-1]};
   // Bit leaving the top digit: the value no longer fits in DIGITS digits.
   assign carry        = adjusted[BCD_MSB];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         shift_bin <= '0;
         scratch   <= '0;
         count     <= '0;
         ovf_latch <= 1'b0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  shift_bin <= bus.binary;
                  scratch   <= '0;
                  count     <= '0;
                  ovf_latch <= 1'b0;
                  busy_q    <= 1'b1;
                  state     <= ST_CONVERT;
               end
            end

            ST_CONVERT: begin
               scratch   <= next_scratch;
               shift_bin <= {shift_bin[BIN_WIDTH-2:0], 1'b0};
               count     <= count + 1'b1;
               if (carry) begin
                  ovf_latch <= 1'b1;
               end
               // The final iteration commits straight from next_scratch so
               // the result appears one edge earlier than via scratch.
               if (count == LAST_COUNT) begin
                  if (ovf_latch || carry) begin
                     bcd_q <= {DIGITS{BCD_NINE}};
                     ovf_q <= 1'b1;
                  end else begin
                     bcd_q <= next_scratch;
                     ovf_q <= 1'b0;
                  end
                  done_q <= 1'b1;
                  state  <= ST_DONE;
               end
            end

            ST_DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end

            default: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.overflow = ovf_q;
   assign bus.bcd      = bcd_q;
   assign bus.state    = state;

endmodule

// File: tb/tb_bin_to_bcd_sequential.sv
// Self-checking bench for bin_to_bcd_sequential: directed cases plus a
// random sweep compared against a decimal reference model.
module tb_bin_to_bcd_sequential;
   import bin_to_bcd_pkg::*;

   localparam int BIN_WIDTH = 20;
   localparam int DIGITS    = 6;
   localparam int BCD_W     = 4 * DIGITS;

   logic clock;
   logic reset;
   int   checks;
   int   failures;
   logic [BCD_W-1:0] prev_bcd;

   bin_to_bcd_sequential_if #(.BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) bus ();

   bin_to_bcd_sequential #(.BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Decimal reference: repeated division by ten, saturating at 10^DIGITS.
   function automatic void ref_model(input int unsigned v,
                                     output logic [BCD_W-1:0] b,
                                     output logic o);
      int unsigned r;
      r = v;
      b = '0;
      o = 1'b0;
      if (v >= 1000000) begin
         for (int d = 0; d < DIGITS; d++) b[d*4 +: 4] = 4'd9;
         o = 1'b1;
      end else begin
         for (int d = 0; d < DIGITS; d++) begin
            b[d*4 +: 4] = 4'(r % 10);
            r = r / 10;
         end
      end
   endfunction

   function automatic logic digits_ok(input logic [BCD_W-1:0] b);
      logic ok;
      ok = 1'b1;
      for (int d = 0; d < DIGITS; d++) if (b[d*4 +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   // ---------------- driver ----------------
   // One full conversion: latency, busy length, single done pulse, result
   // hold before commit, result value and overflow. binary is scrambled
   // during the conversion; it must have no effect.
   task automatic run_conv(input logic [BIN_WIDTH-1:0] val, input string tag);
      logic [BCD_W-1:0] exp_bcd;
      logic             exp_ovf;
      logic [BCD_W-1:0] got_bcd;
      logic             got_ovf;
      int               done_at;
      int               busy_cnt;
      int               done_cnt;
      logic             held;
      ref_model(32'(val), exp_bcd, exp_ovf);
      @(negedge clock);
      bus.start  = 1'b1;
      bus.binary = val;
      @(posedge clock);
      #1 bus.start = 1'b0;
      done_at  = -1;
      busy_cnt = 0;
      done_cnt = 0;
      held     = 1'b1;
      got_bcd  = '0;
      got_ovf  = 1'b0;
      for (int n = 0; n <= 22; n++) begin
         @(negedge clock);
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = n;
               got_bcd = bus.bcd;
               got_ovf = bus.overflow;
            end
         end
         if (done_at < 0 && bus.bcd !== prev_bcd) held = 1'b0;
         bus.binary = BIN_WIDTH'($urandom);
      end
      check_eq({tag, "_latency"}, 32'(done_at), 32'd20);
      check_eq({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
      check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd21);
      check_eq({tag, "_hold"}, 32'(held), 32'd1);
      check_eq({tag, "_bcd"}, 32'(got_bcd), 32'(exp_bcd));
      check_eq({tag, "_ovf"}, 32'(got_ovf), 32'(exp_ovf));
      check_eq({tag, "_digits"}, 32'(digits_ok(got_bcd)), 32'd1);
      prev_bcd = exp_bcd;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int first_at;
      int second_at;
      int dn;
      logic [BCD_W-1:0] b1;
      logic [BCD_W-1:0] b2;
      int unsigned rv;

      checks     = 0;
      failures   = 0;
      prev_bcd   = '0;
      reset      = 1'b0;
      bus.start  = 1'b0;
      bus.binary = '0;

      repeat (3) @(negedge clock);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
      check_eq("rst_bcd", 32'(bus.bcd), 32'd0);
      check_eq("rst_state", 32'(bus.state), 32'(ST_IDLE));
      reset = 1'b1;
      repeat (2) @(negedge clock);

      run_conv(20'd0, "zero");
      run_conv(20'd123456, "v123456");
      run_conv(20'd999999, "v999999");
      run_conv(20'd1000000, "v1000000");
      run_conv(20'hFFFFF, "vfffff");

      // start held high across two IDLE visits, binary changed mid-flight
      @(negedge clock);
      bus.start  = 1'b1;
      bus.binary = 20'd42;
      @(posedge clock);
      dn        = 0;
      first_at  = -1;
      second_at = -1;
      b1        = '0;
      b2        = '0;
      for (int n = 0; n <= 44; n++) begin
         @(negedge clock);
         if (n == 3) bus.binary = 20'd7;
         if (bus.done) begin
            dn++;
            if (first_at < 0) begin
               first_at = n;
               b1 = bus.bcd;
            end else if (second_at < 0) begin
               second_at = n;
               b2 = bus.bcd;
            end
         end
         if (n == 42) bus.start = 1'b0;
      end
      check_eq("hold_first_at", 32'(first_at), 32'd20);
      check_eq("hold_first_bcd", 32'(b1), 32'h000042);
      check_eq("hold_second_at", 32'(second_at), 32'd42);
      check_eq("hold_second_bcd", 32'(b2), 32'h000007);
      check_eq("hold_done_count", 32'(dn), 32'd2);
      prev_bcd = 24'h000007;

      // asynchronous reset in the middle of a conversion
      @(negedge clock);
      bus.start  = 1'b1;
      bus.binary = 20'd999;
      @(posedge clock);
      #1 bus.start = 1'b0;
      repeat (5) @(negedge clock);
      check_eq("mid_busy_before", 32'(bus.busy), 32'd1);
      #2 reset = 1'b0;
      #1;
      check_eq("arst_busy", 32'(bus.busy), 32'd0);
      check_eq("arst_done", 32'(bus.done), 32'd0);
      check_eq("arst_ovf", 32'(bus.overflow), 32'd0);
      check_eq("arst_bcd", 32'(bus.bcd), 32'd0);
      check_eq("arst_state", 32'(bus.state), 32'(ST_IDLE));
      @(negedge clock);
      reset    = 1'b1;
      prev_bcd = '0;
      run_conv(20'd5, "after_rst");

      // random sweep
      for (int i = 0; i < 1000; i++) begin
         rv = $urandom_range(0, 999999);
         repeat ($urandom_range(0, 3)) @(negedge clock);
         run_conv(BIN_WIDTH'(rv), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
